// File: rtl/iorq_rd_fsm_pkg.sv
// Shared types and helpers for the Z8S180 I/O-read end-of-cycle detector.
package iorq_rd_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        BUSY = 2'd2,
        TICK = 2'd3
    } state_t;

    localparam int MIN_CYCLES_DEF = 2;

    // Bits needed to hold a sample count from 0 up to min_cycles.
    function automatic int cnt_width(input int min_cycles);
        return $clog2(min_cycles + 1);
    endfunction

endpackage

// File: rtl/iorq_rd_sync.sv
// Two-flop synchronizer for bus strobes arriving from another clock domain.
module iorq_rd_sync #(
    parameter int WIDTH = 1
) (
    input  logic             phi,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge phi or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/iorq_rd_fsm.sv
// Emits a one-phi pulse after a qualified Z8S180 I/O read (IORQ & RD) ends.
// Define IORQ_RD_FSM_SYNC_EN to synchronize iorq/rd into phi (adds 2 cycles).
module iorq_rd_fsm
    import iorq_rd_fsm_pkg::*;
#(
    parameter int MIN_CYCLES = MIN_CYCLES_DEF
) (
    input  logic phi,
    input  logic reset,
    input  logic iorq,
    input  logic rd,
    output logic rd_tick
);

    localparam int             CW    = cnt_width(MIN_CYCLES);
    localparam logic [CW:0]    MIN_W = (CW + 1)'(MIN_CYCLES);
    localparam logic [CW-1:0]  ONE   = CW'(1);
    localparam state_t         FIRST = (MIN_CYCLES == 1) ? BUSY : QUAL;

    logic        cyc;
    state_t      state;
    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;

`ifdef IORQ_RD_FSM_SYNC_EN
    logic [1:0] strobe_q;

    iorq_rd_sync #(.WIDTH(2)) u_sync (
        .phi   (phi),
        .reset (reset),
        .d     ({iorq, rd}),
        .q     (strobe_q)
    );

    assign cyc = &strobe_q;
`else
    assign cyc = iorq & rd;
`endif

    // Extra bit keeps the compare exact when cnt+1 reaches the top of its range.
    assign cnt_inc = {1'b0, cnt} + (CW + 1)'(1);

    always_ff @(posedge phi or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_tick <= 1'b0;
        end else begin
            rd_tick <= 1'b0;
            case (state)
                // TICK already sampled the next edge, so a fresh cycle starts here.
                IDLE, TICK: begin
                    if (cyc) begin
                        cnt   <= ONE;
                        state <= FIRST;
                    end else begin
                        state <= IDLE;
                    end
                end
                QUAL: begin
                    if (!cyc) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc[CW-1:0];
                        if (cnt_inc == MIN_W)
                            state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!cyc) begin
                        state   <= TICK;
                        rd_tick <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iorq_rd_fsm.sv
// Bench for iorq_rd_fsm: directed bus scenarios plus random bursts vs a run-length model.
module tb_iorq_rd_fsm;

`ifdef IORQ_RD_FSM_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic phi   = 1'b0;
    logic reset = 1'b0;
    logic iorq  = 1'b1;
    logic rd    = 1'b1;
    logic tick1, tick2, tick3;

    int nassert = 0;
    int nfail   = 0;

    // Raw cyc per edge since reset, and what the FSM sees after the optional sync delay.
    bit rawq[$];
    bit hist[$];

    always #25 phi = ~phi;

    iorq_rd_fsm #(.MIN_CYCLES(1)) dut1 (.phi(phi), .reset(reset), .iorq(iorq), .rd(rd), .rd_tick(tick1));
    iorq_rd_fsm                   dut2 (.phi(phi), .reset(reset), .iorq(iorq), .rd(rd), .rd_tick(tick2));
    iorq_rd_fsm #(.MIN_CYCLES(3)) dut3 (.phi(phi), .reset(reset), .iorq(iorq), .rd(rd), .rd_tick(tick3));

    // A tick follows the first 0 after a run of at least min consecutive 1s.
    function automatic bit exp_tick(input int min);
        int n;
        int run;
        n   = hist.size();
        run = 0;
        if (n == 0 || hist[n-1])
            return 1'b0;
        for (int k = n - 2; k >= 0 && hist[k]; k--)
            run++;
        return run >= min;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // One phi period: drive 1 ns after the falling edge, check 1 ns after the rising edge.
    task automatic step(input logic i, input logic r, input logic rst, input string tag);
        @(negedge phi);
        #1;
        iorq  = i;
        rd    = r;
        reset = rst;
        #1;
        if (!rst)
            check({tag, " async"}, tick2, 1'b0);
        @(posedge phi);
        if (!rst) begin
            rawq.delete();
            hist.delete();
        end else begin
            rawq.push_back(i & r);
            hist.push_back(rawq.size() > LAT ? rawq[rawq.size() - 1 - LAT] : 1'b0);
        end
        #1;
        check({tag, " m1"}, tick1, rst ? exp_tick(1) : 1'b0);
        check({tag, " m2"}, tick2, rst ? exp_tick(2) : 1'b0);
        check({tag, " m3"}, tick3, rst ? exp_tick(3) : 1'b0);
    endtask

    task automatic steps(input int n, input logic i, input logic r, input string tag);
        for (int k = 0; k < n; k++)
            step(i, r, 1'b1, tag);
    endtask

    initial begin
        #1;
        check("reset_state", tick2, 1'b0);

        // Reset held with a read strobe active, then released into a fresh cycle.
        step(1'b1, 1'b1, 1'b0, "rst_hold");
        steps(3, 1'b1, 1'b1, "rst_release");
        steps(4, 1'b0, 1'b0, "rst_release_end");

        // T1-T2-TW-T3 read: three samples high, then drop.
        steps(3, 1'b1, 1'b1, "read3");
        steps(4, 1'b0, 1'b0, "read3_end");

        // Late-assert read: two samples high.
        steps(2, 1'b1, 1'b1, "late");
        steps(4, 1'b0, 1'b0, "late_end");

        // Single-sample glitch: only MIN_CYCLES=1 ticks.
        steps(1, 1'b1, 1'b1, "glitch");
        steps(4, 1'b0, 1'b0, "glitch_end");

        // Writes / INTACK and memory reads never count.
        steps(3, 1'b1, 1'b0, "iorq_only");
        steps(3, 1'b0, 1'b1, "rd_only");
        steps(3, 1'b0, 1'b0, "nonread_end");

        // Back-to-back reads with a single idle sample; the tick edge starts the next cycle.
        steps(3, 1'b1, 1'b1, "b2b_a");
        steps(1, 1'b0, 1'b0, "b2b_gap");
        steps(3, 1'b1, 1'b1, "b2b_b");
        steps(4, 1'b0, 1'b0, "b2b_end");

        // Long wait-stated read.
        steps(9, 1'b1, 1'b1, "wait");
        steps(4, 1'b0, 1'b0, "wait_end");

        // Reset while busy discards the cycle.
        steps(4, 1'b1, 1'b1, "rst_busy");
        step(1'b1, 1'b1, 1'b0, "rst_busy_assert");
        steps(5, 1'b0, 1'b0, "rst_busy_after");

        // Reset landing during the tick clears it immediately.
        steps(3, 1'b1, 1'b1, "rst_tick");
        steps(LAT + 1, 1'b0, 1'b0, "rst_tick_edge");
        step(1'b0, 1'b0, 1'b0, "rst_tick_assert");
        steps(3, 1'b0, 1'b0, "rst_tick_after");

        // Random bursts of idle, write, memory-read and I/O-read cycles.
        for (int b = 0; b < 60; b++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 3);
            len  = $urandom_range(1, 5);
            if ($urandom_range(0, 19) == 0)
                step(1'b1, 1'b1, 1'b0, "rand_rst");
            steps(len, kind[1], kind[0], "rand");
        end
        steps(5, 1'b0, 1'b0, "drain");

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule

// File: doc/iorq_rd_fsm.md
Name: iorq_rd_fsm

Overview:
- Detects a completed Z8S180 external I/O read bus cycle, where IORQ and RD are both asserted.
- Emits a single-clock pulse, rd_tick, after the cycle ends.
- Sits in the nouveau-vdp99 bus interface. The pulse drives read side effects such as VRAM read-ahead and pointer increment, or status-flag clear, after the CPU has latched the data.

Parameters:
- MIN_CYCLES, default 2: consecutive phi rising-edge samples with iorq&rd high needed to qualify a cycle. Legal range 1..15.

Ports:
- phi  input  1  CPU clock. All state is updated on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- iorq  input  1  IORQ, positive logic (already inverted from the bus).
- rd  input  1  RD, positive logic.
- rd_tick  output  1  one-phi-cycle pulse marking the end of a qualified I/O read.

Behaviour:
- cyc = iorq & rd, sampled on the phi rising edge.
- Bus timing the block must tolerate:
  - cyc rises 1–25 ns after the T1 falling edge, or coincident with the T2 rising edge.
  - cyc falls between the T3 falling edge and the next T1 rising edge.
- A sample taken at an edge coincident with a cyc transition may see either value; the design must work with both.
- States: IDLE, QUAL, BUSY, TICK. rd_tick is registered: rd_tick = (state == TICK).
- Counter cnt counts qualified samples, width ceil(log2(MIN_CYCLES+1)).
- IDLE:
  - cyc=1: cnt<=1; go to BUSY if MIN_CYCLES==1, else QUAL.
  - cyc=0: stay.
- QUAL:
  - cyc=0: go to IDLE. The glitch or too-short cycle is rejected and no tick is produced.
  - cyc=1: cnt<=cnt+1; go to BUSY when cnt+1 == MIN_CYCLES.
- BUSY:
  - cyc=0: go to TICK.
  - Otherwise stay. There is no timeout; arbitrary wait states are allowed.
- TICK:
  - rd_tick=1 for exactly one phi cycle.
  - Next state is IDLE if cyc=0.
  - If cyc=1 (a new cycle already sampled), load cnt<=1 and go to QUAL or BUSY exactly as from IDLE.
- Latency: rd_tick rises on the first rising edge that samples cyc=0 after BUSY, and stays high for one cycle.
- iorq alone (write or interrupt-acknowledge) or rd alone (memory read) never advances the FSM.
- Reset asserted:
  - Asynchronously forces state=IDLE, cnt=0, rd_tick=0.
  - A cycle in progress is discarded and no tick is produced for it.
- After reset deasserts, operation resumes from IDLE on the next edge. A cyc already high at that point is treated as a new cycle.
- Exactly one rd_tick per qualified cycle; never two consecutive high cycles.

Optional Feature:
- Macro IORQ_RD_FSM_SYNC_EN.
- When defined: iorq and rd each pass through a 2-flop synchronizer clocked by phi before forming cyc. This is for asynchronous or derived-clock sources.
  - Every transition and rd_tick moves 2 phi cycles later.
  - Synchronizer flops reset to 0.
- When undefined: cyc is formed directly from the ports, since they are synchronous to phi. Latency is as stated above.

Decomposition:
- Package iorq_rd_fsm_pkg holds:
  - the state enum (IDLE, QUAL, BUSY, TICK);
  - the default MIN_CYCLES constant;
  - the counter-width function.
- One natural sub-module: iorq_rd_sync, a 2-flop synchronizer with async active-low reset, instantiated only under IORQ_RD_FSM_SYNC_EN.

Test Plan:
- Reset: hold reset low 50 ns with iorq=rd=1 → rd_tick=0 throughout. Release → FSM treats cyc as a new cycle.
- T1-T2-TW-T3 read: iorq=rd rise 1 ns after T1 fall, held 3 phi cycles, drop at T1 rise → exactly one rd_tick, high for 50 ns (one period), starting at the first rising edge sampling 0.
- Late-assert read: iorq=rd rise at T2 rise, drop 1 ns after T3 fall → one rd_tick on the next rising edge; no double pulse.
- Glitch: cyc high for 1 sample with MIN_CYCLES=2 → no rd_tick. Repeat with MIN_CYCLES=1 → one rd_tick.
- Non-read cycles: iorq only for 3 cycles, then rd only for 3 cycles → rd_tick stays 0.
- Reset mid-cycle: assert reset while in BUSY, release, cyc low → no rd_tick. With IORQ_RD_FSM_SYNC_EN, the scenario 2 tick arrives 2 cycles later.
